// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: opcodes, the memory-stage
// state encoding and the writeback record carried out of the memory stage.
package cpu_pkg;

  localparam int XLEN = 16;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SHL = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_LI  = 4'h7;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_BEQ = 4'hA;
  localparam logic [3:0] OP_BNE = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_JAL = 4'hD;
  localparam logic [3:0] OP_NOP = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic {
    MS_IDLE     = 1'b0,
    MS_MEM_WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [3:0]      dst_reg;
    logic            wr_en;
    logic            halt;
    logic            err;
  } wb_rec_t;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_req_ctrl.sv
// Data-memory request sequencer: holds the latched request while waiting for
// mem_ack and aborts after MEM_TIMEOUT unacknowledged cycles.
module mem_req_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_o  = 1'b0;
    err_o   = 1'b0;
    case (state_q)
      MS_IDLE: begin
        if (start_i) begin
          state_d = MS_MEM_WAIT;
          cnt_d   = '0;
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
        end
      end
      MS_MEM_WAIT: begin
        // An ack in the final allowed cycle still completes normally.
        if (mem_ack_i) begin
          done_o  = 1'b1;
          state_d = MS_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          err_o   = 1'b1;
          state_d = MS_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MS_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_req_o   = (state_q == MS_MEM_WAIT);
  assign busy_o      = (state_q == MS_MEM_WAIT);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign rdata_o     = mem_rdata_i;

endmodule

// File: rtl/mem_stage.sv
// CPU memory stage: passes ALU results through, runs LW/SW against data memory
// and presents one registered writeback record per retired instruction.
// Optional macro MEM_ALIGN_CHECK_EN faults odd-address LW/SW without a request.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [3:0]        ex_opcode,
  input  logic [DATA_W-1:0] ex_aluout,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [3:0]        ex_dst_reg,
  input  logic              ex_wr_en,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [3:0]        wb_dst_reg,
  output logic              wb_wr_en,
  output logic              wb_halt,
  output logic              wb_err,
  output logic              halted
);

  wb_rec_t     wb_q, wb_d;
  logic        wb_valid_q, wb_valid_d;
  logic        halted_q, halted_d;
  logic [3:0]  dst_pend_q, dst_pend_d;

  logic              accept;
  logic              misaligned;
  logic              start;
  logic              busy;
  logic              mem_done;
  logic              mem_err;
  logic [DATA_W-1:0] mem_rd;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = ex_aluout[0];
`else
  assign misaligned = 1'b0;
`endif

  assign ex_ready = !busy && !halted_q && (!wb_valid_q || wb_ready);
  assign accept   = ex_valid && ex_ready;

  mem_req_ctrl #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .DATA_W      (DATA_W)
  ) u_req_ctrl (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .we_i        (ex_opcode == OP_SW),
    .addr_i      (ex_aluout),
    .wdata_i     (ex_store_data),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .busy_o      (busy),
    .done_o      (mem_done),
    .err_o       (mem_err),
    .rdata_o     (mem_rd)
  );

  always_comb begin
    wb_d       = wb_q;
    wb_valid_d = wb_valid_q;
    halted_d   = halted_q;
    dst_pend_d = dst_pend_q;
    start      = 1'b0;

    if (wb_valid_q && wb_ready) begin
      wb_d       = '0;
      wb_valid_d = 1'b0;
    end

    // Accept and memory completion are mutually exclusive: accept needs IDLE.
    if (accept) begin
      if (is_mem_op(ex_opcode)) begin
        if (misaligned) begin
          wb_d         = '0;
          wb_d.data    = ex_aluout;
          wb_d.dst_reg = ex_dst_reg;
          wb_d.err     = 1'b1;
          wb_valid_d   = 1'b1;
        end else begin
          start      = 1'b1;
          dst_pend_d = ex_dst_reg;
        end
      end else begin
        wb_d.data    = ex_aluout;
        wb_d.dst_reg = ex_dst_reg;
        wb_d.wr_en   = ex_wr_en && (ex_opcode != OP_HLT);
        wb_d.halt    = (ex_opcode == OP_HLT);
        wb_d.err     = 1'b0;
        wb_valid_d   = 1'b1;
        if (ex_opcode == OP_HLT) begin
          halted_d = 1'b1;
        end
      end
    end else if (mem_done) begin
      wb_d.data    = mem_we ? mem_addr : mem_rd;
      wb_d.dst_reg = dst_pend_q;
      wb_d.wr_en   = !mem_we;
      wb_d.halt    = 1'b0;
      wb_d.err     = 1'b0;
      wb_valid_d   = 1'b1;
    end else if (mem_err) begin
      wb_d         = '0;
      wb_d.dst_reg = dst_pend_q;
      wb_d.err     = 1'b1;
      wb_valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q       <= '0;
      wb_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      dst_pend_q <= '0;
    end else begin
      wb_q       <= wb_d;
      wb_valid_q <= wb_valid_d;
      halted_q   <= halted_d;
      dst_pend_q <= dst_pend_d;
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_q.data;
  assign wb_dst_reg = wb_q.dst_reg;
  assign wb_wr_en   = wb_q.wr_en;
  assign wb_halt    = wb_q.halt;
  assign wb_err     = wb_q.err;
  assign halted     = halted_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 16-bit pipelined CPU; sits directly downstream of the execute-stage ALU and consumes its 16-bit result.
- LW/SW use the ALU result as a byte address and run a variable-latency req/ack transaction to data memory.
- All other opcodes pass the ALU result straight through.
- Presents one registered writeback record per retired instruction, with valid/ready handshakes on both sides.

Parameters:
- MEM_TIMEOUT, 64: max cycles mem_req may stay high without mem_ack before the op is aborted with an error.
- DATA_W, 16: data/address width; only 16 is supported.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  upstream record valid.
- ex_ready  out  1  stage can accept a record this cycle.
- ex_opcode  in  4  instruction opcode.
- ex_aluout  in  16  ALU result; address for LW/SW.
- ex_store_data  in  16  SW write data.
- ex_dst_reg  in  4  destination register.
- ex_wr_en  in  1  record writes the register file.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1 = write (SW), 0 = read (LW).
- mem_addr  out  16  memory byte address.
- mem_wdata  out  16  memory write data.
- mem_ack  in  1  single-cycle completion strobe.
- mem_rdata  in  16  read data, valid with mem_ack.
- wb_valid  out  1  writeback record valid.
- wb_ready  in  1  writeback accepts the record.
- wb_data  out  16  result or load data.
- wb_dst_reg  out  4  destination register.
- wb_wr_en  out  1  register write enable.
- wb_halt  out  1  record is HLT.
- wb_err  out  1  record faulted (timeout or misalignment).
- halted  out  1  sticky; HLT has retired.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; all outputs 0 (wb_*, mem_*, halted, timeout counter). Reset mid-transaction drops mem_req on the next edge; any late mem_ack is ignored.
- FSM states: IDLE, MEM_WAIT.
- ex_ready = (state==IDLE) && !halted && (!wb_valid || wb_ready). Accept = ex_valid && ex_ready.
- Output register: cleared when wb_valid && wb_ready, unless a new record loads in the same cycle.
- Non-memory op accepted: the next edge loads wb_* (wb_data=ex_aluout, wr_en/dst passed through); latency 1. Back-to-back accepts give 1 record/cycle while wb_ready=1.
- HLT (4'hF) accepted: the record retires with wb_halt=1, wb_wr_en=0, and halted is set on the same edge. halted stays set until rst; ex_ready stays 0.
- LW (4'h8) / SW (4'h9) accepted: next edge sets state=MEM_WAIT; mem_req=1, mem_addr=ex_aluout, mem_we=(SW), mem_wdata=ex_store_data. Address, we and wdata are latched and stay stable while mem_req=1.
- In MEM_WAIT, on mem_ack=1:
  - Next edge: mem_req=0, state=IDLE, wb_valid=1.
  - LW: wb_data=mem_rdata captured at the ack edge, wb_wr_en=1.
  - SW: wb_wr_en=0, wb_data=address.
  - Minimum LW/SW latency: 2 cycles from accept to wb_valid when ack comes in the first request cycle.
- Timeout: the counter increments each MEM_WAIT cycle without ack. When it reaches MEM_TIMEOUT-1 with no ack, the next edge retires the record with wb_err=1, wb_wr_en=0, wb_data=0, mem_req=0.
- Ack and timeout in the same cycle: the ack wins and the op completes normally.
- mem_ack outside MEM_WAIT is ignored.
- wb_* hold stable while wb_valid && !wb_ready.
- Memory completion is only possible with the output register free, because accept required it.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: an LW/SW with ex_aluout[0]=1 issues no mem_req and retires after 1 cycle with wb_err=1, wb_wr_en=0, wb_data=ex_aluout.
- Undefined: no check; the odd address is sent to memory unchanged.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_ADD..OP_HLT (4'h0..4'hF), including OP_LW=4'h8, OP_SW=4'h9, OP_HLT=4'hF;
  - the mem-stage state enum;
  - the writeback record struct (data, dst_reg, wr_en, halt, err).
- One sub-module: mem_req_ctrl. It owns the MEM_WAIT FSM, the latched request fields and the timeout counter, and returns done/err/rdata strobes.

Test Plan:
- ADD record, ex_aluout=16'h1234, dst=3, wb_ready=1 → next cycle wb_valid=1, wb_data=16'h1234, wb_dst_reg=3, wb_wr_en=1; three back-to-back ops retire on consecutive cycles.
- LW addr=16'h0040, mem_ack 3 cycles after mem_req with rdata=16'hBEEF → mem_req high exactly 3 cycles with addr stable, then wb_data=16'hBEEF, wb_wr_en=1; ex_ready=0 throughout.
- SW addr=16'h0010, data=16'hA5A5, immediate ack → mem_we=1, mem_wdata=16'hA5A5; wb_valid 2 cycles after accept with wb_wr_en=0.
- LW with no ack, MEM_TIMEOUT=4 → mem_req high 4 cycles, then wb_err=1, wb_wr_en=0; the following ADD proceeds normally.
- wb_ready=0 for 5 cycles with an ADD pending → wb_* stable, ex_ready=0; on release the record retires once and the next record is accepted.
- HLT, then ex_valid held high → wb_halt=1 and halted=1; ex_ready stays 0 until rst. With MEM_ALIGN_CHECK_EN: LW addr=16'h0003 → no mem_req, wb_err=1 after 1 cycle.
